// File: rtl/mfm_flux_classifier_pkg.sv
// Shared floppy read-path definitions: interval class codes, FSM states and
// the cell-timing threshold derivation used by the classifier and the decoder.
package mfm_flux_classifier_pkg;

  typedef enum logic [1:0] {
    CLS_2T  = 2'd0,
    CLS_3T  = 2'd1,
    CLS_4T  = 2'd2,
    CLS_ERR = 2'd3
  } cls_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam int unsigned CLKSPD_DEF     = 32'd25000000;
  localparam int unsigned BITRATE_DEF    = 32'd500000;
  localparam int unsigned IDLE_CELLS_DEF = 32'd64;
  localparam int unsigned HALF_DEF       = CLKSPD_DEF / (32'd2 * BITRATE_DEF);
  localparam int unsigned IDLE_CYC_DEF   = IDLE_CELLS_DEF * HALF_DEF;
  localparam int unsigned CW_DEF         = $clog2(IDLE_CYC_DEF + 32'd1);

  // Boundaries sit halfway between nominal cell lengths and belong to the upper class.
  function automatic cls_e classify(input logic [31:0] ival, input int unsigned half);
    int unsigned t_min;
    int unsigned t_23;
    int unsigned t_34;
    int unsigned t_max;
    t_min = (32'd3 * half) / 32'd2;
    t_23  = (32'd5 * half) / 32'd2;
    t_34  = (32'd7 * half) / 32'd2;
    t_max = (32'd9 * half) / 32'd2;
    if (ival < t_min)      return CLS_ERR;
    else if (ival < t_23)  return CLS_2T;
    else if (ival < t_34)  return CLS_3T;
    else if (ival < t_max) return CLS_4T;
    else                   return CLS_ERR;
  endfunction

endpackage

// File: rtl/mfm_flux_classifier_if.sv
// Classified-interval bus from the flux classifier to the sector decoder.
interface mfm_flux_classifier_if
  import mfm_flux_classifier_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
);
  logic          o_Valid;
  logic [1:0]    o_Class;
  logic [CW-1:0] o_Count;
  logic          o_Idle;
  logic [7:0]    o_ErrCount;

  modport master (output o_Valid, output o_Class, output o_Count, output o_Idle, output o_ErrCount);
  modport slave  (input  o_Valid, input  o_Class, input  o_Count, input  o_Idle, input  o_ErrCount);
endinterface

// File: rtl/mfm_flux_classifier_sync_fall_edge.sv
// Two-flop synchronizer plus falling-edge detector; all flops reset high so
// releasing reset can never fabricate an edge.
module sync_fall_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic fall
);
  logic meta_r;
  logic sync_r;
  logic prev_r;

  // Synchronizer chain and previous-value flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= 1'b1;
      sync_r <= 1'b1;
      prev_r <= 1'b1;
    end else begin
      meta_r <= din;
      sync_r <= meta_r;
      prev_r <= sync_r;
    end
  end

  assign fall = prev_r & ~sync_r;
endmodule

// File: rtl/mfm_flux_classifier.sv
// Floppy RDATA front-end: measures flux-edge spacing, classifies each interval
// as 2T/3T/4T/error, and flags loss of flux.
module mfm_flux_classifier
  import mfm_flux_classifier_pkg::*;
#(
  parameter int unsigned clkspd     = CLKSPD_DEF,
  parameter int unsigned bitrate    = BITRATE_DEF,
  parameter int unsigned idle_cells = IDLE_CELLS_DEF
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Data,
  mfm_flux_classifier_if.master bus
);
  localparam int unsigned HALF     = clkspd / (32'd2 * bitrate);
  localparam int unsigned IDLE_CYC = idle_cells * HALF;
  localparam int unsigned CW       = $clog2(IDLE_CYC + 32'd1);
  localparam logic [CW-1:0] CNT_MAX = CW'(IDLE_CYC);
  localparam logic [CW-1:0] CNT_TMO = CW'(IDLE_CYC - 32'd1);

  logic          edge_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] ival_s;
  cls_e          cls_calc_s;
  state_e        state_r, state_s;
  logic          valid_r, valid_s;
  cls_e          cls_r, cls_s;
  logic [CW-1:0] count_r, count_s;
  logic          idle_r, idle_s;
  logic [7:0]    err_r, err_s;

  sync_fall_edge u_sync (
    .clk   (i_Clk),
    .rst_n (i_Rst_L),
    .din   (i_Data),
    .fall  (edge_s)
  );

  // Clocks since the last edge detect, saturating at the idle limit
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L)            cnt_r <= '0;
    else if (edge_s)         cnt_r <= '0;
    else if (cnt_r < CNT_MAX) cnt_r <= cnt_r + CW'(1);
    else                     cnt_r <= cnt_r;
  end

  // Interval between edge detects; cnt lags by one so add one, then saturate
  always_comb begin
    if (cnt_r >= CNT_MAX) ival_s = CNT_MAX;
    else                  ival_s = cnt_r + CW'(1);
    cls_calc_s = classify(32'(ival_s), HALF);
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    valid_s = 1'b0;
    cls_s   = cls_r;
    count_s = count_r;
    err_s   = err_r;
    case (state_r)
      ST_IDLE: begin
        if (edge_s) state_s = ST_RUN;
        else        state_s = ST_IDLE;
      end
      ST_RUN: begin
        // An edge on the timeout cycle still counts as a (saturated) interval
        if (edge_s) begin
          state_s = ST_RUN;
          valid_s = 1'b1;
          cls_s   = cls_calc_s;
          count_s = ival_s;
          if (cls_calc_s == CLS_ERR && err_r != 8'hFF) err_s = err_r + 8'd1;
          else                                         err_s = err_r;
        end else if (cnt_r == CNT_TMO) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
    idle_s = (state_s == ST_IDLE);
  end

  // State and registered outputs
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      cls_r   <= CLS_ERR;
      count_r <= '0;
      idle_r  <= 1'b1;
      err_r   <= 8'd0;
    end else begin
      state_r <= state_s;
      valid_r <= valid_s;
      cls_r   <= cls_s;
      count_r <= count_s;
      idle_r  <= idle_s;
      err_r   <= err_s;
    end
  end

  assign bus.o_Valid    = valid_r;
  assign bus.o_Class    = cls_r;
  assign bus.o_Count    = count_r;
  assign bus.o_Idle     = idle_r;
  assign bus.o_ErrCount = err_r;
endmodule

// File: tb/tb_mfm_flux_classifier.sv
// Scoreboard bench for mfm_flux_classifier: directed flux trains push expected
// (class, count) pairs; a negedge monitor pops and compares on every strobe.
module tb_mfm_flux_classifier;
  logic i_Clk = 1'b0;
  logic i_Rst_L = 1'b0;
  logic i_Data = 1'b1;

  mfm_flux_classifier_if #(.CW(11)) bus ();

  mfm_flux_classifier dut (
    .i_Clk   (i_Clk),
    .i_Rst_L (i_Rst_L),
    .i_Data  (i_Data),
    .bus     (bus)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int cls;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  task automatic expect_strobe(input int c, input int n);
    exp_t e;
    e.cls = c;
    e.cnt = n;
    sb_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation
  always @(negedge i_Clk) begin
    exp_t e;
    if (i_Rst_L === 1'b1 && bus.o_Valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = sb_q.pop_front();
        check("strobe_class", int'(bus.o_Class), e.cls);
        check("strobe_count", int'(bus.o_Count), e.cnt);
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_valid"}, int'(bus.o_Valid), 0);
    check({tag, "_class"}, int'(bus.o_Class), 3);
    check({tag, "_count"}, int'(bus.o_Count), 0);
    check({tag, "_idle"}, int'(bus.o_Idle), 1);
    check({tag, "_errcount"}, int'(bus.o_ErrCount), 0);
  endtask

  task automatic apply_reset();
    i_Data = 1'b1;
    i_Rst_L = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    check_reset_vals("rst");
    i_Rst_L = 1'b1;
    @(posedge i_Clk);
    #1;
  endtask

  // Falling pin edge now; the next flux() edge lands exactly n clocks later
  task automatic flux(input int n);
    i_Data = 1'b0;
    repeat (3) @(posedge i_Clk);
    #1;
    i_Data = 1'b1;
    repeat (n - 3) @(posedge i_Clk);
    #1;
  endtask

  int iv[8] = '{36, 37, 61, 62, 86, 87, 111, 112};
  int cl[8] = '{3, 0, 0, 1, 1, 2, 2, 3};

  initial begin
    // Quiet line after reset
    apply_reset();
    repeat (5000) @(posedge i_Clk);
    #1;
    check("quiet_valid", int'(bus.o_Valid), 0);
    check("quiet_idle", int'(bus.o_Idle), 1);
    check("quiet_errcount", int'(bus.o_ErrCount), 0);
    check("quiet_class", int'(bus.o_Class), 3);

    // Nominal 2T/3T/4T cells; idle drops one clock after the arming detect
    apply_reset();
    i_Data = 1'b0;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #1;
    check("arm_idle_at_detect", int'(bus.o_Idle), 1);
    @(posedge i_Clk); #1;
    check("arm_idle_after_detect", int'(bus.o_Idle), 0);
    i_Data = 1'b1;
    repeat (47) @(posedge i_Clk);
    #1;
    expect_strobe(0, 50);
    flux(75);
    expect_strobe(1, 75);
    flux(100);
    expect_strobe(2, 100);
    flux(20);
    check("nominal_errcount", int'(bus.o_ErrCount), 0);
    check("nominal_idle", int'(bus.o_Idle), 0);

    // Threshold boundaries
    apply_reset();
    flux(iv[0]);
    for (int i = 0; i < 8; i++) begin
      expect_strobe(cl[i], iv[i]);
      flux((i < 7) ? iv[i + 1] : 20);
    end
    check("boundary_errcount", int'(bus.o_ErrCount), 2);

    // Edge exactly at the timeout wins; a longer gap drops to idle and re-arms
    apply_reset();
    flux(50);
    expect_strobe(0, 50);
    flux(1600);
    expect_strobe(3, 1600);
    flux(50);
    check("edge_wins_idle", int'(bus.o_Idle), 0);
    repeat (1700) @(posedge i_Clk);
    #1;
    check("timeout_idle", int'(bus.o_Idle), 1);
    flux(50);
    check("rearm_idle", int'(bus.o_Idle), 0);
    expect_strobe(0, 50);
    flux(20);
    check("timeout_errcount", int'(bus.o_ErrCount), 1);

    // Glitch train saturates the error counter
    apply_reset();
    flux(10);
    for (int i = 0; i < 300; i++) begin
      expect_strobe(3, 10);
      flux((i < 299) ? 10 : 20);
    end
    check("glitch_errcount_sat", int'(bus.o_ErrCount), 255);

    // Asynchronous reset mid-interval, then re-arm
    apply_reset();
    flux(50);
    expect_strobe(0, 50);
    flux(20);
    check("pre_reset_count", int'(bus.o_Count), 50);
    check("pre_reset_idle", int'(bus.o_Idle), 0);
    #3;
    i_Rst_L = 1'b0;
    #1;
    check_reset_vals("async_rst");
    repeat (5) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    @(posedge i_Clk);
    #1;
    flux(50);
    expect_strobe(0, 50);
    flux(20);

    repeat (10) @(posedge i_Clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
